// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared types and constants for the dino sprite renderer:
//   rgb_t        12-bit {r,g,b} pixel colour
//   pos_t        10-bit {x,y} screen position
//   H_VISIBLE / V_VISIBLE   active-area size of the 640x480 raster
//   DEF_FG_RGB / DEF_BG_RGB / BLACK_RGB   default colours
//   DINO_ROWS / DINO_BITMAP 16x16 1-bpp dino artwork (row-major, bit r*16+c)
// -----------------------------------------------------------------------------
package dino_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    localparam rgb_t DEF_FG_RGB = 12'h222;
    localparam rgb_t DEF_BG_RGB = 12'hFFF;
    localparam rgb_t BLACK_RGB  = 12'h000;

    // Artwork as drawn: one word per row, MSB is the leftmost column.
    localparam logic [15:0] DINO_ROWS [16] = '{
        16'h00FE, 16'h01BF, 16'h01FF, 16'h01F0,
        16'h01FC, 16'h83C0, 16'hC7F0, 16'hEFD0,
        16'hFFC0, 16'h7FC0, 16'h3F80, 16'h1F00,
        16'h0E00, 16'h0D80, 16'h0880, 16'h0CC0
    };

    // Flatten the artwork so that ROM address row*16+col selects one bit.
    function automatic logic [255:0] dino_bitmap();
        logic [255:0] bits;
        bits = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                bits[r*16 + c] = DINO_ROWS[r][15 - c];
            end
        end
        return bits;
    endfunction

    localparam logic [255:0] DINO_BITMAP = dino_bitmap();

endpackage

// File: rtl/dino_sprite_rom.sv
// -----------------------------------------------------------------------------
// dino_sprite_rom
// DEPTH x 1-bit sprite bitmap with a synchronous one-cycle read, written so it
// maps onto block RAM / LUT RAM initialised with the bitmap contents.
//   clk_i   pixel clock
//   addr_i  bit address (row * SPRITE_W + col)
//   data_o  bitmap bit, valid one cycle after addr_i
// -----------------------------------------------------------------------------
module dino_sprite_rom
    import dino_pkg::*;
#(
    parameter int unsigned       DEPTH  = 256,
    parameter int unsigned       ADDR_W = 8,
    parameter logic [DEPTH-1:0]  INIT   = DINO_BITMAP
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              data_o
);

    // NOTE: the read register has no reset so the tools can absorb it into the
    // RAM primitive; its value is masked downstream until a real pixel arrives.
    always_ff @(posedge clk_i) begin
        data_o <= INIT[addr_i];
    end

endmodule

// File: rtl/dino_sprite_renderer.sv
// -----------------------------------------------------------------------------
// dino_sprite_renderer
// Pixel-colour stage behind the VGA timing generator. Draws one scaled 1-bpp
// dino sprite over a flat background; syncs are delayed to match the two-cycle
// pixel pipeline. Sprite moves are requested via valid/ready and only take
// effect at the frame boundary (x==0, y==480), so a frame is never torn.
//
// Ports:
//   clk_i, rst_ni                      pixel clock, async active-low reset
//   hsync_i, vsync_i, visible_i        timer syncs (active low) and active flag
//   position_x_i, position_y_i         raster position
//   sprite_x_i, sprite_y_i             requested sprite top-left
//   sprite_valid_i / sprite_ready_o    position update handshake
//   hsync_o, vsync_o                   syncs delayed by 2 cycles
//   red_o, green_o, blue_o             pixel colour, 2-cycle latency
//   frame_o                            1-cycle pulse aligned with the outputs
//
// Build option: define DINO_GROUND_EN to draw a 1-pixel ground line in FG_RGB
// on row GROUND_Y wherever the sprite is not opaque.
// -----------------------------------------------------------------------------
module dino_sprite_renderer
    import dino_pkg::*;
#(
    parameter int unsigned SPRITE_W   = 16,
    parameter int unsigned SPRITE_H   = 16,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_BITMAP = DINO_BITMAP,
    parameter rgb_t        FG_RGB     = DEF_FG_RGB,
`ifdef DINO_GROUND_EN
    parameter logic [9:0]  GROUND_Y   = 10'd400,
`endif
    parameter rgb_t        BG_RGB     = DEF_BG_RGB
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       visible_i,
    input  logic [9:0] position_x_i,
    input  logic [9:0] position_y_i,
    input  logic [9:0] sprite_x_i,
    input  logic [9:0] sprite_y_i,
    input  logic       sprite_valid_i,
    output logic       sprite_ready_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [3:0] red_o,
    output logic [3:0] green_o,
    output logic [3:0] blue_o,
    output logic       frame_o
);

    localparam int unsigned DEPTH  = SPRITE_W * SPRITE_H;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [10:0] BOX_W  = 11'(SPRITE_W << SCALE_LOG2);
    localparam logic [10:0] BOX_H  = 11'(SPRITE_H << SCALE_LOG2);

    // -------------------------------------------------------------------------
    // Position update handshake
    // -------------------------------------------------------------------------
    pos_t act_q, act_d;
    pos_t pend_q, pend_d;
    logic pending_q, pending_d;
    logic frame_start;

    assign frame_start = (position_x_i == '0) && (position_y_i == 10'(V_VISIBLE));

    // Ready is simply "no update waiting": a second request cannot overwrite
    // one that has not yet been applied.
    assign sprite_ready_o = ~pending_q;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        act_d     = act_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        // Apply a waiting update at the boundary.
        if (frame_start && pending_q) begin
            act_d     = pend_q;
            pending_d = 1'b0;
        end
        // Capture only while ready; since ready == !pending this never collides
        // with the apply above, so a request in the boundary cycle with nothing
        // pending simply waits for the next frame.
        if (sprite_valid_i && sprite_ready_o) begin
            pend_d    = '{x: sprite_x_i, y: sprite_y_i};
            pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q     <= '0;
            pend_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            act_q     <= act_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 0 (combinational): sprite-relative coordinates and ROM address
    // -------------------------------------------------------------------------
    logic [10:0]       rel_x, rel_y;
    logic              on_screen;
    logic              in_box;
    logic [ADDR_W-1:0] rom_addr;

    assign rel_x = {1'b0, position_x_i} - {1'b0, act_q.x};
    assign rel_y = {1'b0, position_y_i} - {1'b0, act_q.y};

    // A raster left of/above the sprite gives a negative difference, which as
    // an unsigned 11-bit value is >= 1024 and so fails the box test without a
    // separate sign check. No wrap-around is possible.
    assign on_screen = (position_x_i < 10'(H_VISIBLE)) && (position_y_i < 10'(V_VISIBLE));
    assign in_box    = on_screen && (rel_x < BOX_W) && (rel_y < BOX_H);

    always_comb begin
        rom_addr = '0;
        if (in_box) begin
            rom_addr = ADDR_W'(((32'(rel_y) >> SCALE_LOG2) * SPRITE_W)
                               + (32'(rel_x) >> SCALE_LOG2));
        end
    end

    logic rom_bit;

    dino_sprite_rom #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .INIT   (SPRITE_BITMAP)
    ) u_rom (
        .clk_i  (clk_i),
        .addr_i (rom_addr),
        .data_o (rom_bit)
    );

    // -------------------------------------------------------------------------
    // Stage 1 registers (aligned with the ROM read)
    // -------------------------------------------------------------------------
    logic in_box_q, vis1_q, hs1_q, vs1_q, frame1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_box_q <= 1'b0;
            vis1_q   <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            frame1_q <= 1'b0;
        end else begin
            in_box_q <= in_box;
            vis1_q   <= visible_i;
            hs1_q    <= hsync_i;
            vs1_q    <= vsync_i;
            frame1_q <= frame_start;
        end
    end

`ifdef DINO_GROUND_EN
    logic ground1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ground1_q <= 1'b0;
        end else begin
            ground1_q <= (position_y_i == GROUND_Y);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Stage 2: colour select and output registers
    // -------------------------------------------------------------------------
    rgb_t rgb_d, rgb_q;
    logic hs2_q, vs2_q, frame2_q;

    always_comb begin
        rgb_d = BLACK_RGB;
        if (vis1_q) begin
            if (in_box_q && rom_bit) begin
                rgb_d = FG_RGB;
            end
`ifdef DINO_GROUND_EN
            else if (ground1_q) begin
                rgb_d = FG_RGB;
            end
`endif
            else begin
                rgb_d = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q    <= BLACK_RGB;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            frame2_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            frame2_q <= frame1_q;
        end
    end

    assign red_o   = rgb_q.r;
    assign green_o = rgb_q.g;
    assign blue_o  = rgb_q.b;
    assign hsync_o = hs2_q;
    assign vsync_o = vs2_q;
    assign frame_o = frame2_q;

endmodule
